// File: rtl/pipe_collector_if.sv
// Bundle between an upstream cipher pipeline stage, the result collector and its consumer.
// The slave modport is the collector's view; master is the surrounding logic's view.
interface pipe_collector_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          en;
  logic          done;
  logic [127:0]  state;
  logic [127:0]  key;
  logic [3:0]    num;
  logic          out_ready;
  logic          out_valid;
  logic [127:0]  out_state;
  logic [127:0]  out_key;
  logic [CW-1:0] count;
  logic          full;
  logic          overflow;
  logic [7:0]    drop_cnt;

  modport slave (
    input  en, done, state, key, num, out_ready,
    output out_valid, out_state, out_key, count, full, overflow, drop_cnt
  );

  modport master (
    output en, done, state, key, num, out_ready,
    input  out_valid, out_state, out_key, count, full, overflow, drop_cnt
  );
endinterface

// File: rtl/pipe_collector.sv
// Buffers finished cipher results (state + key at the final round) in a small FIFO.
// Results arriving while the buffer is full and not draining are dropped and counted.
module pipe_collector #(
  parameter int         DEPTH     = 4,
  parameter logic [3:0] FINAL_NUM = 4'hA
) (
  input  logic           clk,
  input  logic           rst,
  pipe_collector_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [127:0]  mem_state [DEPTH];
  logic [127:0]  mem_key   [DEPTH];
  logic [AW-1:0] wr_ptr = '0;
  logic [AW-1:0] rd_ptr = '0;
  logic [CW-1:0] cnt    = '0;
  logic          ovf    = 1'b0;
  logic [7:0]    drops  = 8'h00;

  logic not_empty;
  logic is_full;
  logic push_req;
  logic pop;
  logic push_ok;
  logic drop;

  assign not_empty = (cnt != '0);
  assign is_full   = (cnt == FULL_CNT);
  assign push_req  = bus.en & bus.done & (bus.num == FINAL_NUM);
  assign pop       = not_empty & bus.out_ready;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign push_ok   = push_req & (~is_full | pop);
  assign drop      = push_req & is_full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      mem_state[wr_ptr] <= bus.state;
      mem_key[wr_ptr]   <= bus.key;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      drops  <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drops != 8'hFF) drops <= drops + 8'h01;
      end
    end
  end

  // Stale storage stays hidden once the buffer is empty, including after reset.
  assign bus.out_valid = not_empty;
  assign bus.out_state = not_empty ? mem_state[rd_ptr] : 128'b0;
  assign bus.out_key   = not_empty ? mem_key[rd_ptr]   : 128'b0;
  assign bus.count     = cnt;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf;
  assign bus.drop_cnt  = drops;
endmodule

// File: doc/pipe_collector.md
PIPE_COLLECTOR -- requirements
Module: pipe_collector

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of result entries buffered (power of two, 2..16).
REQ-002 Parameter FINAL_NUM, default 4'hA, meaning the round number that marks a finished cipher result.
REQ-003 Port clk  input  1  single clock; all state updates on posedge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port en  input  1  capture enable; low blocks new captures only.
REQ-006 Port done  input  1  upstream pipeline-stage valid flag.
REQ-007 Port state  input  128  upstream state; byte k at state[8k+:8], column-major (byte 0 = row0/col0, byte 1 = row1/col0).
REQ-008 Port key  input  128  upstream round key, same byte layout.
REQ-009 Port num  input  4  upstream round number.
REQ-010 Port out_ready  input  1  downstream accepts head entry.
REQ-011 Port out_valid  output  1  head entry available.
REQ-012 Port out_state  output  128  head entry state.
REQ-013 Port out_key  output  128  head entry key.
REQ-014 Port count  output  $clog2(DEPTH)+1  entries held.
REQ-015 Port full  output  1  count == DEPTH.
REQ-016 Port overflow  output  1  sticky: a qualifying result was dropped.
REQ-017 Port drop_cnt  output  8  saturating count of dropped results.

Function
REQ-018 Qualifying input (push request): en=1, done=1, num==FINAL_NUM, sampled at posedge; done with any other num is ignored, no flag change.
REQ-019 Pop: out_valid=1 and out_ready=1 at posedge; head entry removed.
REQ-020 Push accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle; entry written at tail, tail pointer advances mod DEPTH.
REQ-021 Push with count==DEPTH and no same-cycle pop: entry discarded, overflow set to 1, drop_cnt increments, saturating at 8'hFF.
REQ-022 Simultaneous accepted push and pop: count unchanged, both pointers advance.
REQ-023 Pointers wrap from DEPTH-1 to 0; ordering strictly first-in first-out across wrap.
REQ-024 Push latency: entry visible on out_valid/out_state/out_key the cycle after the capturing posedge (1-cycle latency); no same-cycle bypass.
REQ-025 out_valid = (count != 0); out_state/out_key combinationally reflect head entry; when count==0 both drive 128'b0.
REQ-026 Pop with out_valid=0 is ignored (out_ready may stay high).
REQ-027 en=0 suppresses pushes only; pops, count, and flags continue to operate.
REQ-028 overflow and drop_cnt clear only on rst.

Reset
REQ-029 rst=1 at posedge: count=0, pointers=0, out_valid=0, out_state=0, out_key=0, full=0, overflow=0, drop_cnt=0; rst wins over simultaneous push/pop.
REQ-030 Reset mid-operation discards all buffered entries; storage contents need not be cleared but must be unobservable (out_* forced 0 while empty).
REQ-031 Power-up initial values equal reset values.

Verification
REQ-032 Single push: en=1, done=1, num=4'hA, state=128'h3925841d02dc09fbdc118597196a0b32 -> next cycle out_valid=1, out_state equals that value, count=1.
REQ-033 Filter: done=1 with num=4'h5 for 3 cycles -> out_valid stays 0, count=0, overflow=0.
REQ-034 Fill/overflow: out_ready=0, 5 qualifying pushes (states 1..5) -> count=4, full=1, overflow=1, drop_cnt=1; then out_ready=1 -> pops return 1,2,3,4 in order, then out_valid=0.
REQ-035 Full with simultaneous push+pop: count=4, push state 9 with out_ready=1 -> count stays 4, overflow unchanged, state 9 emerges after the three remaining older entries.
REQ-036 Wrap stress: 20 pushes interleaved with pops at random out_ready, never exceeding DEPTH -> output order equals input order, drop_cnt=0.
REQ-037 Reset mid-stream: count=3, assert rst one cycle with a concurrent push -> count=0, out_valid=0, out_state=0, overflow=0, drop_cnt=0 next cycle.
